stack_sequencer: RTL and testbench

//  Executes MiniRISC stack transfers: 1-word push (JSR: PC), 2-word push (IRQ entry: PC, flags),
//  1-word pop (RTS: PC), 2-word pop (RTI: flags, PC) on the shared data-memory bus.

---
 rtl/stack_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_stack_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// Stack transfer engine: pushes/pops one or two words (PC, flags) over the shared
// data bus with a req/grant handshake, and owns the empty-descending stack pointer.
module stack_sequencer #(
    parameter logic [7:0] SP_INIT  = 8'hFF,
    parameter logic [7:0] SP_LIMIT = 8'hC0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       op_start,
    input  logic       op_push,
    input  logic       op_two,
    input  logic [7:0] push_pc,
    input  logic [7:0] push_flags,
    output logic       op_end,
    output logic [7:0] pop_pc,
    output logic [7:0] pop_flags,
    output logic       bus_req,
    input  logic       bus_grant,
    output logic [7:0] bus_addr,
    output logic       bus_wr,
    output logic       bus_rd,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic [7:0] sp,
    output logic       stk_ovf,
    output logic       stk_unf
);

    typedef enum logic [1:0] {IDLE, XFER0, XFER1, DONE} state_t;

    state_t     state_q, state_d;
    logic       push_q, push_d;
    logic       two_q, two_d;
    logic [7:0] word0_q, word0_d;
    logic [7:0] word1_q, word1_d;
    logic [7:0] sp_q, sp_d;
    logic [7:0] pop_pc_q, pop_pc_d;
    logic [7:0] pop_flags_q, pop_flags_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       op_end_q, op_end_d;
    logic       bus_req_q, bus_req_d;
    logic       bus_wr_q, bus_wr_d;
    logic       bus_rd_q, bus_rd_d;
    logic [7:0] bus_addr_q, bus_addr_d;
    logic [7:0] bus_wdata_q, bus_wdata_d;

    logic [1:0] n_words;
    logic       push_fail;
    logic       pop_fail;

    // Bounds are evaluated 9 bits wide so that neither direction can wrap SP.
    always_comb begin
        n_words   = op_two ? 2'd2 : 2'd1;
        push_fail = ({1'b0, sp_q} + 9'd1) < ({1'b0, SP_LIMIT} + {7'd0, n_words});
        pop_fail  = ({1'b0, sp_q} + {7'd0, n_words}) > {1'b0, SP_INIT};
    end

    always_comb begin
        state_d     = state_q;
        push_d      = push_q;
        two_d       = two_q;
        word0_d     = word0_q;
        word1_d     = word1_q;
        sp_d        = sp_q;
        pop_pc_d    = pop_pc_q;
        pop_flags_d = pop_flags_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;

        case (state_q)
            IDLE: begin
                if (op_start) begin
                    push_d  = op_push;
                    two_d   = op_two;
                    word0_d = push_pc;
                    word1_d = push_flags;
                    if (!op_push) begin
                        pop_pc_d    = 8'd0;
                        pop_flags_d = 8'd0;
                    end
                    if (op_push && push_fail) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else if (!op_push && pop_fail) begin
                        unf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = XFER0;
                    end
                end
            end
            XFER0, XFER1: begin
                if (bus_grant) begin
                    if (push_q) begin
                        sp_d = sp_q - 8'd1;
                    end else begin
                        sp_d = sp_q + 8'd1;
                        // A two-word pop meets the flags first, then the PC.
                        if (state_q == XFER0 && two_q) begin
                            pop_flags_d = bus_rdata;
                        end else begin
                            pop_pc_d = bus_rdata;
                        end
                    end
                    state_d = (state_q == XFER0 && two_q) ? XFER1 : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (init) begin
            state_d     = IDLE;
            push_d      = 1'b0;
            two_d       = 1'b0;
            word0_d     = 8'd0;
            word1_d     = 8'd0;
            sp_d        = SP_INIT;
            pop_pc_d    = 8'd0;
            pop_flags_d = 8'd0;
            ovf_d       = 1'b0;
            unf_d       = 1'b0;
        end

        // Bus outputs are registered, so they are derived from the next-state values.
        op_end_d    = (state_d == DONE);
        bus_req_d   = (state_d == XFER0) || (state_d == XFER1);
        bus_wr_d    = bus_req_d & push_d;
        bus_rd_d    = bus_req_d & ~push_d;
        bus_addr_d  = !bus_req_d ? 8'd0 : (push_d ? sp_d : sp_d + 8'd1);
        bus_wdata_d = !bus_wr_d ? 8'd0 : ((state_d == XFER0) ? word0_d : word1_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            push_q      <= 1'b0;
            two_q       <= 1'b0;
            word0_q     <= 8'd0;
            word1_q     <= 8'd0;
            sp_q        <= SP_INIT;
            pop_pc_q    <= 8'd0;
            pop_flags_q <= 8'd0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            op_end_q    <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_rd_q    <= 1'b0;
            bus_addr_q  <= 8'd0;
            bus_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            push_q      <= push_d;
            two_q       <= two_d;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            sp_q        <= sp_d;
            pop_pc_q    <= pop_pc_d;
            pop_flags_q <= pop_flags_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            op_end_q    <= op_end_d;
            bus_req_q   <= bus_req_d;
            bus_wr_q    <= bus_wr_d;
            bus_rd_q    <= bus_rd_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign op_end    = op_end_q;
    assign pop_pc    = pop_pc_q;
    assign pop_flags = pop_flags_q;
    assign bus_req   = bus_req_q;
    assign bus_wr    = bus_wr_q;
    assign bus_rd    = bus_rd_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign sp        = sp_q;
    assign stk_ovf   = ovf_q;
    assign stk_unf   = unf_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: a stack-level model predicts bus accesses and
// completions into queues; a monitor compares them as the DUT presents them.
module tb_stack_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic       op_start = 1'b0;
    logic       op_push = 1'b0;
    logic       op_two = 1'b0;
    logic [7:0] push_pc = 8'd0;
    logic [7:0] push_flags = 8'd0;
    logic       op_end;
    logic [7:0] pop_pc;
    logic [7:0] pop_flags;
    logic       bus_req;
    logic       bus_grant = 1'b0;
    logic [7:0] bus_addr;
    logic       bus_wr;
    logic       bus_rd;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic [7:0] sp;
    logic       stk_ovf;
    logic       stk_unf;

    stack_sequencer dut (
        .clk(clk), .rst(rst), .init(init),
        .op_start(op_start), .op_push(op_push), .op_two(op_two),
        .push_pc(push_pc), .push_flags(push_flags),
        .op_end(op_end), .pop_pc(pop_pc), .pop_flags(pop_flags),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_addr(bus_addr),
        .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        bit         wr;
        logic [7:0] data;
    } acc_t;

    typedef struct {
        logic [7:0] sp;
        logic       ovf;
        logic       unf;
        bit         chk_pc;
        logic [7:0] pc;
        bit         chk_fl;
        logic [7:0] fl;
        int         lat;
        int         start;
    } done_t;

    acc_t       acc_q[$];
    done_t      done_q[$];
    logic [7:0] slave_mem [256];
    logic [7:0] model_mem [256];
    logic [7:0] msp = 8'hFF;
    logic       movf = 1'b0;
    logic       munf = 1'b0;
    int         gmode = 0;   // 0: grant tied high, 1: random grant, 2: driven by the test
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    bit         done_flag = 1'b0;

    assign bus_rdata = slave_mem[bus_addr];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        if (gmode == 0) bus_grant = 1'b1;
        else if (gmode == 1) bus_grant = ($urandom_range(0, 2) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        acc_q.delete();
        done_q.delete();
        msp  = 8'hFF;
        movf = 1'b0;
        munf = 1'b0;
    endtask

    // Stack-level prediction: push stores PC then flags downward; pop returns the
    // topmost words (flags above PC for a two-word frame).
    task automatic issue_op(input bit push, input bit two, input logic [7:0] pc,
                            input logic [7:0] fl, input int hold);
        done_t d;
        acc_t  a;
        int    n;
        bit    fail;
        n = two ? 2 : 1;
        d.chk_pc = 1'b0; d.chk_fl = 1'b0; d.pc = 8'd0; d.fl = 8'd0;
        if (push) begin
            fail = (int'(msp) - n + 1) < 'hC0;
            if (fail) movf = 1'b1;
            else begin
                a.wr = 1'b1; a.addr = msp; a.data = pc;
                acc_q.push_back(a);
                if (two) begin
                    a.addr = msp - 8'd1; a.data = fl;
                    acc_q.push_back(a);
                    model_mem[msp - 8'd1] = fl;
                end
                model_mem[msp] = pc;
                msp = msp - 8'(n);
            end
        end else begin
            fail = (int'(msp) + n) > 255;
            if (fail) begin
                munf = 1'b1;
                d.chk_pc = 1'b1; d.chk_fl = 1'b1;
            end else begin
                a.wr = 1'b0; a.data = 8'd0;
                for (int w = 1; w <= n; w++) begin
                    a.addr = msp + 8'(w);
                    acc_q.push_back(a);
                end
                d.chk_pc = 1'b1;
                d.pc = model_mem[msp + 8'(n)];
                if (two) begin
                    d.chk_fl = 1'b1;
                    d.fl = model_mem[msp + 8'd1];
                end
                msp = msp + 8'(n);
            end
        end
        d.sp = msp; d.ovf = movf; d.unf = munf;
        d.lat = (gmode == 0) ? (fail ? 1 : n + 1) : -1;
        d.start = cyc;
        done_q.push_back(d);
        $display("op push=%0b two=%0b pc=%02h fl=%02h -> sp=%02h fail=%0b", push, two, pc, fl, msp, fail);
        op_push = push; op_two = two; push_pc = pc; push_flags = fl;
        op_start = 1'b1;
        repeat (hold) step();
        op_start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done_flag && k < 200) begin
            step();
            k++;
        end
        if (!done_flag) begin
            n_cmp++;
            n_err++;
            $display("FAIL op_end_timeout: got none expected op_end within 200 cycles");
            acc_q.delete();
            done_q.delete();
        end
        done_flag = 1'b0;
    endtask

    task automatic do_op(input bit push, input bit two, input logic [7:0] pc, input logic [7:0] fl);
        issue_op(push, two, pc, fl, 1);
        wait_done();
    endtask

    acc_t  ma;
    done_t md;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_req) begin
                if (acc_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL bus_req_unexpected: got req addr=%0h expected no request", bus_addr);
                end else begin
                    ma = acc_q[0];
                    chk("bus_addr", bus_addr, ma.addr);
                    chk("bus_wr", bus_wr, ma.wr);
                    chk("bus_rd", bus_rd, !ma.wr);
                    chk("bus_wdata", bus_wdata, ma.data);
                    if (bus_grant) begin
                        if (bus_wr) slave_mem[bus_addr] = bus_wdata;
                        void'(acc_q.pop_front());
                    end
                end
            end else begin
                chk("bus_idle", {bus_addr, bus_wdata, bus_wr, bus_rd}, 32'd0);
            end
            if (op_end) begin
                if (done_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL op_end_unexpected: got op_end expected none");
                end else begin
                    md = done_q.pop_front();
                    chk("sp", sp, md.sp);
                    chk("stk_ovf", stk_ovf, md.ovf);
                    chk("stk_unf", stk_unf, md.unf);
                    if (md.chk_pc) chk("pop_pc", pop_pc, md.pc);
                    if (md.chk_fl) chk("pop_flags", pop_flags, md.fl);
                    if (md.lat >= 0) chk("latency", cyc - md.start, md.lat);
                    chk("accesses_left", acc_q.size(), 0);
                    done_flag = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 8'(i * 7 + 3);
            model_mem[i] = 8'(i * 7 + 3);
        end
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("reset_sp", sp, 8'hFF);
        chk("reset_outs", {op_end, bus_req, bus_wr, bus_rd, stk_ovf, stk_unf}, 0);
        chk("reset_pop", {pop_pc, pop_flags, bus_addr, bus_wdata}, 0);
        step();

        // Pop from an empty stack: no bus access, underflow, op_end one cycle after start.
        gmode = 0;
        do_op(1'b0, 1'b0, 8'h00, 8'h00);
        init = 1'b1;
        step();
        init = 1'b0;
        model_reset();
        #1;
        chk("init_sp", sp, 8'hFF);
        chk("init_flags", {stk_ovf, stk_unf}, 0);
        step();

        // IRQ frame push then RTI pop with grant tied high.
        do_op(1'b1, 1'b1, 8'h3A, 8'h05);
        do_op(1'b0, 1'b1, 8'h00, 8'h00);

        // Grant withheld for 4 cycles: request must hold steady and SP move once.
        gmode = 2;
        bus_grant = 1'b0;
        issue_op(1'b1, 1'b0, 8'h77, 8'h00, 1);
        repeat (4) step();
        bus_grant = 1'b1;
        step();
        bus_grant = 1'b0;
        wait_done();

        // Fill down to the limit, then a frame that would cross it.
        gmode = 0;
        while (msp != 8'hC0) do_op(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        do_op(1'b1, 1'b1, 8'hAA, 8'hBB);
        do_op(1'b1, 1'b0, 8'hCC, 8'h00);
        do_op(1'b0, 1'b0, 8'h00, 8'h00);

        // Reset while the second word of a push is pending.
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        step();
        gmode = 2;
        bus_grant = 1'b0;
        issue_op(1'b1, 1'b1, 8'h11, 8'h22, 1);
        step();
        bus_grant = 1'b1;
        step();
        bus_grant = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_bus_req", bus_req, 1'b0);
        chk("rst_mid_sp", sp, 8'hFF);
        model_reset();
        step();
        rst = 1'b0;
        repeat (3) step();
        gmode = 0;
        step();
        do_op(1'b1, 1'b0, 8'h5C, 8'h00);
        do_op(1'b0, 1'b0, 8'h00, 8'h00);

        // Random mix with random grant timing and occasional long op_start.
        gmode = 1;
        for (int i = 0; i < 150; i++) begin
            issue_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom), 8'($urandom), $urandom_range(1, 2));
            wait_done();
        end
        repeat (3) step();
        chk("final_queues", acc_q.size() + done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
